// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
package uart_frame_pkg;

  localparam int unsigned BYTE_W = 8;

  // Default frame start marker
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_LEN  = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_e;

endpackage : uart_frame_pkg

// File: rtl/frame_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [BYTE_W-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Write one payload byte; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule : frame_buf

// File: rtl/uart_frame_decoder.sv
// Hunts for a sync byte, collects a length-prefixed payload and checks its additive checksum.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] iData,
  input  logic              iValid,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [BYTE_W-1:0] oRdData,
  output logic [BYTE_W-1:0] oLen,
  output logic              oFrameValid,
  output logic              oChkErr,
  output logic              oLenErr,
  output logic              oTimeout,
  output logic              oBusy
);

  localparam int unsigned MAX_LEN = 2 ** ADDR_W;
  // Count width holds 0..MAX_LEN so LEN == MAX_LEN never wraps the compare
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned LCMP_W  = BYTE_W + 1;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT);

  state_e            state_q;
  logic              ivalid_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BYTE_W-1:0] sum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [BYTE_W-1:0] olen_q;
  logic              frame_q;
  logic              chk_err_q;
  logic              len_err_q;
  logic              tmo_strb_q;
  logic              busy_q;

  logic              evt_c;
  logic              len_ok_c;
  logic              last_c;
  logic              tmo_hit_c;
  logic              wr_en_c;

  // Rising edge of iValid marks exactly one event per received byte
  assign evt_c     = iValid & ~ivalid_q;
  assign len_ok_c  = (iData != '0) && (LCMP_W'(iData) <= LCMP_W'(MAX_LEN));
  assign last_c    = (cnt_q + CNT_W'(1)) == len_q;
  // A byte event in the expiry cycle takes priority over the timeout
  assign tmo_hit_c = (state_q != IDLE) && !evt_c && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign wr_en_c   = evt_c && (state_q == GET_DATA);

  frame_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (cnt_q[ADDR_W-1:0]),
    .wr_data_i (iData),
    .rd_addr_i (iRdAddr),
    .rd_data_o (oRdData)
  );

  // Decoder FSM with edge detect, checksum, timeout and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ivalid_q   <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      olen_q     <= '0;
      frame_q    <= 1'b0;
      chk_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_strb_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ivalid_q   <= iValid;
      frame_q    <= 1'b0;
      chk_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      tmo_strb_q <= 1'b0;

      if ((state_q == IDLE) || evt_c || tmo_hit_c) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (tmo_hit_c) begin
        tmo_strb_q <= 1'b1;
        state_q    <= IDLE;
        busy_q     <= 1'b0;
      end else if (evt_c) begin
        case (state_q)
          IDLE: begin
            if (iData == SYNC_BYTE) begin
              state_q <= GET_LEN;
              busy_q  <= 1'b1;
            end
          end
          GET_LEN: begin
            if (len_ok_c) begin
              len_q   <= CNT_W'(iData);
              sum_q   <= iData;
              cnt_q   <= '0;
              state_q <= GET_DATA;
            end else begin
              len_err_q <= 1'b1;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end
          end
          GET_DATA: begin
            sum_q <= sum_q + iData;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
              state_q <= GET_CHK;
            end
          end
          GET_CHK: begin
            if (sum_q == iData) begin
              olen_q  <= BYTE_W'(len_q);
              frame_q <= 1'b1;
            end else begin
              chk_err_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oLen        = olen_q;
  assign oFrameValid = frame_q;
  assign oChkErr     = chk_err_q;
  assign oLenErr     = len_err_q;
  assign oTimeout    = tmo_strb_q;
  assign oBusy       = busy_q;

endmodule : uart_frame_decoder

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: stimulus pushes expected events, a monitor checks strobes.
module tb_uart_frame_decoder;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 2 ** ADDR_W;
  localparam int TIMEOUT = 4096;

  typedef enum int {E_FRAME = 0, E_CHK = 1, E_LEN = 2, E_TMO = 3} ev_e;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        iData;
  logic              iValid;
  logic [ADDR_W-1:0] iRdAddr;
  logic [7:0]        oRdData;
  logic [7:0]        oLen;
  logic              oFrameValid, oChkErr, oLenErr, oTimeout, oBusy;

  int   total = 0;
  int   bad   = 0;
  ev_e  exp_q[$];
  logic [7:0] model_buf [MAX_LEN];
  bit         model_vld [MAX_LEN];
  int         model_len = 0;

  uart_frame_decoder #(
    .SYNC_BYTE (8'hA5),
    .ADDR_W    (ADDR_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iData       (iData),
    .iValid      (iValid),
    .iRdAddr     (iRdAddr),
    .oRdData     (oRdData),
    .oLen        (oLen),
    .oFrameValid (oFrameValid),
    .oChkErr     (oChkErr),
    .oLenErr     (oLenErr),
    .oTimeout    (oTimeout),
    .oBusy       (oBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // hold == 0 picks a random hold of 1..3 cycles
  task automatic send_byte(input logic [7:0] b, input int hold);
    int h;
    h = (hold == 0) ? int'($urandom_range(1, 3)) : hold;
    iData  = b;
    iValid = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    iValid = 1'b0;
    iData  = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  // Reference model: outcome derived from the frame rules, pushed before the deciding byte
  task automatic run_frame(input logic [7:0] len, input logic [7:0] pl[$],
                           input logic [7:0] chk, input int hold);
    int sum;
    send_byte(8'hA5, hold);
    if (len == 0 || int'(len) > MAX_LEN) begin
      exp_q.push_back(E_LEN);
      send_byte(len, hold);
      return;
    end
    send_byte(len, hold);
    sum = int'(len);
    for (int i = 0; i < int'(len); i++) begin
      sum += int'(pl[i]);
      model_buf[i] = pl[i];
      model_vld[i] = 1'b1;
      send_byte(pl[i], hold);
    end
    if ((sum % 256) == int'(chk)) begin
      model_len = int'(len);
      exp_q.push_back(E_FRAME);
    end else begin
      exp_q.push_back(E_CHK);
    end
    send_byte(chk, hold);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_len"}, int'(oLen), 0);
    check({tag, "_strobes"}, int'({oFrameValid, oChkErr, oLenErr, oTimeout}), 0);
    check({tag, "_busy"}, int'(oBusy), 0);
  endtask

  // Monitor: every strobe is matched against the head of the expectation queue
  initial begin
    ev_e e;
    int  n;
    int  kind;
    iRdAddr = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) continue;
      n = int'(oFrameValid) + int'(oChkErr) + int'(oLenErr) + int'(oTimeout);
      if (n == 0) continue;
      check("strobe_count", n, 1);
      kind = oFrameValid ? 0 : oChkErr ? 1 : oLenErr ? 2 : 3;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", kind, -1);
        continue;
      end
      e = exp_q.pop_front();
      check("strobe_kind", kind, int'(e));
      check("olen", int'(oLen), model_len);
      check("busy_after", int'(oBusy), 0);
      for (int i = 0; i < MAX_LEN; i++) begin
        if (model_vld[i]) begin
          iRdAddr = ADDR_W'(i);
          #0.2;
          check($sformatf("buf[%0d]", i), int'(oRdData), int'(model_buf[i]));
        end
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] len;
    int sum;
    int r;

    reset  = 1'b1;
    iValid = 1'b0;
    iData  = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) model_vld[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");
    @(posedge clk); #1;

    // Good frame, 3-cycle holds
    q = {8'h11, 8'h22, 8'h33};
    run_frame(8'h03, q, 8'h69, 3);
    // Bad checksum keeps previous oLen and upper buffer
    q = {8'h10, 8'h20};
    run_frame(8'h02, q, 8'h00, 0);
    // Length errors
    q = {};
    run_frame(8'h00, q, 8'h00, 0);
    run_frame(8'(MAX_LEN + 1), q, 8'h00, 0);
    check_idle_busy: begin
      @(negedge clk);
      check("lenerr_busy", int'(oBusy), 0);
      @(posedge clk); #1;
    end

    // Timeout mid-payload, then a good frame
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    model_buf[0] = 8'h55;
    model_vld[0] = 1'b1;
    exp_q.push_back(E_TMO);
    send_byte(8'h55, 0);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    q = {8'h01, 8'h02};
    run_frame(8'h02, q, 8'h05, 0);

    // Noise then sync inside payload
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    q = {8'hA5};
    run_frame(8'h01, q, 8'hA6, 0);

    // Reset in the middle of the payload
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    model_buf[0] = 8'h11;
    model_buf[1] = 8'h22;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_len = 0;
    check_idle("midreset");
    q = {8'h07, 8'h08, 8'h09};
    run_frame(8'h03, q, 8'h1B, 0);

    // Randomized frames, including MAX_LEN and sync-valued payload bytes
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 8) begin
        repeat ($urandom_range(1, 3)) begin
          send_byte((8'($urandom) == 8'hA5) ? 8'h00 : 8'h3C, 0);
        end
      end
      if (r == 7) begin
        len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
      end else begin
        len = (it % 7 == 0) ? 8'(MAX_LEN) : 8'($urandom_range(1, MAX_LEN));
      end
      q = {};
      sum = int'(len);
      for (int i = 0; i < int'(len) && r != 7; i++) begin
        q.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom));
        sum += int'(q[i]);
      end
      if (r == 5 || r == 6) begin
        sum += int'($urandom_range(1, 255));
      end
      run_frame(len, q, 8'(sum % 256), 0);
    end

    repeat (20) @(posedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_frame_decoder

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-to-frame decoder placed directly downstream of the UART receiver. It consumes the receiver's byte/valid pair and hunts for a sync byte. It then collects a length-prefixed payload into an internal buffer and verifies an 8-bit additive checksum. Each verified frame is reported with a one-cycle strobe, and the payload is exposed through a random-access read port for the command layer.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- ADDR_W, 4: payload buffer address width; MAX_LEN = 2**ADDR_W bytes.
- TIMEOUT, 4096: inter-byte timeout in clk cycles; legal range ≥ 2.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- iData  in  8  received byte from UART receiver; stable while iValid high.
- iValid  in  1  receiver valid; level held for several cycles per byte.
- iRdAddr  in  ADDR_W  payload read address.
- oRdData  out  8  payload byte at iRdAddr; combinational read of buffer.
- oLen  out  8  payload length of last verified frame.
- oFrameValid  out  1  one-cycle strobe: frame verified.
- oChkErr  out  1  one-cycle strobe: checksum mismatch.
- oLenErr  out  1  one-cycle strobe: LEN = 0 or LEN > MAX_LEN.
- oTimeout  out  1  one-cycle strobe: frame aborted by inter-byte timeout.
- oBusy  out  1  high while not in IDLE.

## Operation
- Byte event: iValid = 1 and registered iValid_d = 0. One event per received byte, regardless of how long iValid stays high.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
- Requirement: CHK = (LEN + sum of payload) mod 256, accumulated in 8 bits with wrap.
- FSM states: IDLE, GET_LEN, GET_DATA, GET_CHK.
  - IDLE: an event with iData == SYNC_BYTE → GET_LEN. Other bytes are ignored.
  - GET_LEN: LEN in 1..MAX_LEN → latch the length in a counter, set sum = LEN, set wr_ptr = 0, go to GET_DATA. Otherwise pulse oLenErr and go to IDLE.
  - GET_DATA: write buf[wr_ptr] = iData, sum += iData, wr_ptr++. After the LEN-th byte → GET_CHK. SYNC_BYTE is treated as ordinary data here.
  - GET_CHK: sum == iData → latch oLen = LEN and pulse oFrameValid. Otherwise pulse oChkErr. Either way → IDLE.
- Timeout counter: cleared on every byte event and while in IDLE, and increments otherwise. At TIMEOUT-1 with no event that cycle, pulse oTimeout and go to IDLE.
- Buffer and oLen persist after oFrameValid until the next frame's first payload write.
- Data remains valid only until the next frame's first payload write. A consumer must read the buffer before then.
- oRdData returns buf[iRdAddr]. Contents beyond oLen are stale.

## Timing
- All outputs are registered except oRdData.
- Strobes go high for exactly one cycle, in the cycle after the clk edge that samples the CHK/LEN byte event.
- Latency: byte event to state/buffer update is one cycle.
- Reset values:
  - oLen = 0; all strobes = 0; oBusy = 0.
  - State = IDLE; iValid_d = 0; counters = 0.
  - Buffer contents are not cleared.
- Reset mid-frame discards the partial frame with no strobe.
- iValid already high when reset releases: iValid_d = 0 after reset, so this counts as an event. This is accepted; the IDLE sync filter rejects spurious data.
- Simultaneous byte event and timeout expiry: the event wins, and the counter clears.
- sum and LEN arithmetic wrap modulo 256. LEN = MAX_LEN is legal; wr_ptr does not overflow.

## Structure
- Package uart_frame_pkg holds:
  - state enum (IDLE, GET_LEN, GET_DATA, GET_CHK)
  - default SYNC_BYTE
  - byte width constant
- Sub-module frame_buf: 2**ADDR_W x 8 register file with one synchronous write port and one asynchronous read port.
- FSM, edge detect, checksum and timeout logic stay in the top module.

## Test plan
- Good frame: A5, 03, 11, 22, 33, CHK 0x69, with iValid held 3 cycles per byte → exactly one oFrameValid, oLen = 3, reads at addr 0..2 = 11, 22, 33.
- Bad checksum: A5, 02, 10, 20, CHK 0x00 → one oChkErr pulse, no oFrameValid, oLen and buffer of the previous good frame unchanged at addrs ≥ 2.
- Length errors: A5, 00 → oLenErr. A5, 2**ADDR_W+1 → oLenErr. Both cases return to IDLE, oBusy = 0.
- Timeout: A5, 02, 55, then silence for TIMEOUT cycles → one oTimeout pulse. A following good frame decodes correctly.
- Noise and sync-in-data: 00, FF, then A5, 01, A5, CHK 0xA6 → oFrameValid, buf[0] = A5.
- Reset mid-frame: assert reset during GET_DATA → all strobes 0, oLen = 0, oBusy = 0. The next good frame is decoded.
